// File: rtl/wb_pkg.sv
// Shared sizing, grant encoding and FIFO entry layout for the register-file write arbiter.
package wb_pkg;

  localparam int WIDTH      = 32;
  localparam int REGBITS    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

  typedef struct packed {
    logic [REGBITS-1:0] dst;
    logic [WIDTH-1:0]   data;
  } entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// ALU / sample / register-file write bundle; slave is the arbiter side, master the environment side.
interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH
);
  import wb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               alu_valid;
  logic [REGBITS-1:0] alu_dst;
  logic [WIDTH-1:0]   alu_data;
  logic               alu_stall;
  logic               smp_valid;
  logic               smp_ready;
  logic [REGBITS-1:0] smp_dst;
  logic [WIDTH-1:0]   smp_data;
  logic               regwrite;
  logic [REGBITS-1:0] dst_addr;
  logic [WIDTH-1:0]   data_in;
  logic [CW-1:0]      fifo_count;
  logic [15:0]        starve_cnt;

  modport slave (
    input  alu_valid, alu_dst, alu_data, smp_valid, smp_dst, smp_data,
    output alu_stall, smp_ready, regwrite, dst_addr, data_in, fifo_count, starve_cnt
  );

  modport master (
    output alu_valid, alu_dst, alu_data, smp_valid, smp_dst, smp_data,
    input  alu_stall, smp_ready, regwrite, dst_addr, data_in, fifo_count, starve_cnt
  );

endinterface

// File: rtl/wb_sample_fifo.sv
// Sample FIFO with registered pointers; full/empty come from registered count, so a
// freshly pushed entry is never visible for popping until the following cycle.
module wb_sample_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = wb_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output entry_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Push is refused when full even if a pop happens in the same cycle.
  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU results and buffered codec samples onto the register-file write port.
// Build with WB_ARB_STATS_EN defined to count forced ALU stalls on starve_cnt.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH,
  parameter int STARVE_MAX = wb_pkg::STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

  grant_e             w_grant;
  entry_t             w_smp_in;
  entry_t             w_head;
  logic [AW:0]        w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_starve_hit;
  logic [7:0]         w_starve_nxt;
  logic [7:0]         r_starve;
  logic               r_alu_stall;
  logic               r_regwrite;
  logic [REGBITS-1:0] r_dst;
  logic [WIDTH-1:0]   r_data;

  assign w_smp_in.dst  = bus.smp_dst;
  assign w_smp_in.data = bus.smp_data;
  assign w_pop         = (w_grant == GRANT_FIFO);

  wb_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.smp_valid),
    .i_data  (w_smp_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_grant = IDLE;
    if (bus.alu_valid && !r_alu_stall) begin
      w_grant = GRANT_ALU;
    end else if (!w_empty) begin
      w_grant = GRANT_FIFO;
    end else begin
      w_grant = IDLE;
    end
  end

  // Only ALU grants over a waiting sample count toward starvation.
  always_comb begin
    w_starve_nxt = r_starve;
    w_starve_hit = 1'b0;
    if (w_empty) begin
      w_starve_nxt = 8'd0;
    end else if (w_grant == GRANT_ALU) begin
      if (r_starve + 8'd1 == LP_STARVE_MAX) begin
        w_starve_nxt = 8'd0;
        w_starve_hit = 1'b1;
      end else begin
        w_starve_nxt = r_starve + 8'd1;
      end
    end else begin
      w_starve_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve    <= 8'd0;
      r_alu_stall <= 1'b0;
      r_regwrite  <= 1'b0;
      r_dst       <= '0;
      r_data      <= '0;
    end else begin
      r_starve    <= w_starve_nxt;
      r_alu_stall <= w_starve_hit;
      case (w_grant)
        GRANT_ALU: begin
          r_regwrite <= 1'b1;
          r_dst      <= bus.alu_dst;
          r_data     <= bus.alu_data;
        end
        GRANT_FIFO: begin
          r_regwrite <= 1'b1;
          r_dst      <= w_head.dst;
          r_data     <= w_head.data;
        end
        default: begin
          r_regwrite <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] r_starve_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 16'd0;
    end else if (w_starve_hit && (r_starve_cnt != 16'hFFFF)) begin
      r_starve_cnt <= r_starve_cnt + 16'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  assign bus.starve_cnt = r_starve_cnt;
`else
  assign bus.starve_cnt = 16'd0;
`endif

  assign bus.alu_stall  = r_alu_stall;
  assign bus.smp_ready  = !w_full;
  assign bus.regwrite   = r_regwrite;
  assign bus.dst_addr   = r_dst;
  assign bus.data_in    = r_data;
  assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for single-cycle behaviour, hand sequences for
// starvation, FIFO-full backpressure and asynchronous reset.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic [31:0] adata;
    logic        sv;
    logic [3:0]  sd;
    logic [31:0] sdata;
    logic        rw;
    logic [3:0]  dst;
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        stall;
  } vec_t;

  vec_t vecs [10];

`ifdef WB_ARB_STATS_EN
  localparam logic [15:0] EXP_STATS = 16'd1;
`else
  localparam logic [15:0] EXP_STATS = 16'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] adata,
                       input logic sv, input logic [3:0] sd, input logic [31:0] sdata);
    @(negedge clk);
    bus.alu_valid = av;
    bus.alu_dst   = ad;
    bus.alu_data  = adata;
    bus.smp_valid = sv;
    bus.smp_dst   = sd;
    bus.smp_data  = sdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rw, input logic [3:0] dst,
                         input logic [31:0] data, input logic [2:0] cnt, input logic stall);
    chk({tag, ".regwrite"}, 32'(bus.regwrite), 32'(rw));
    if (rw) begin
      chk({tag, ".dst_addr"}, 32'(bus.dst_addr), 32'(dst));
      chk({tag, ".data_in"}, bus.data_in, data);
    end else begin
      chk({tag, ".hold_dst"}, 32'(bus.dst_addr), 32'(dst));
    end
    chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(cnt));
    chk({tag, ".smp_ready"}, 32'(bus.smp_ready), 32'(cnt != 3'd4));
    chk({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(stall));
  endtask

  initial begin
    //            av   ad    adata          sv   sd    sdata         rw   dst   data           cnt   stall
    vecs[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,      1'b1, 4'd3, 32'hDEADBEEF, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,      1'b0, 4'd3, 32'hDEADBEEF, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 32'h100,    1'b0, 4'd3, 32'hDEADBEEF, 3'd1, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd8, 32'h200,    1'b1, 4'd7, 32'h100,      3'd1, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,      1'b1, 4'd8, 32'h200,      3'd0, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,      1'b0, 4'd8, 32'h200,      3'd0, 1'b0};
    vecs[6] = '{1'b1, 4'd5, 32'h55,       1'b1, 4'd9, 32'h900,    1'b1, 4'd5, 32'h55,       3'd1, 1'b0};
    vecs[7] = '{1'b1, 4'd5, 32'h66,       1'b0, 4'd0, 32'h0,      1'b1, 4'd5, 32'h66,       3'd1, 1'b0};
    vecs[8] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,      1'b1, 4'd9, 32'h900,      3'd0, 1'b0};
    vecs[9] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,      1'b0, 4'd9, 32'h900,      3'd0, 1'b0};

    reset         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_dst   = 4'd0;
    bus.alu_data  = 32'd0;
    bus.smp_valid = 1'b0;
    bus.smp_dst   = 4'd0;
    bus.smp_data  = 32'd0;
    repeat (3) tick();
    chk_out("reset", 1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
    chk("reset.data_in", bus.data_in, 32'd0);
    chk("reset.starve_cnt", 32'(bus.starve_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release.smp_ready", 32'(bus.smp_ready), 32'd1);
    chk("release.fifo_count", 32'(bus.fifo_count), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].ad, vecs[i].adata, vecs[i].sv, vecs[i].sd, vecs[i].sdata);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].rw, vecs[i].dst, vecs[i].data,
              vecs[i].cnt, vecs[i].stall);
    end

    // Starvation: one queued sample behind continuous ALU traffic.
    drive(1'b1, 4'd1, 32'h1000, 1'b1, 4'hA, 32'hAAAA);
    tick();
    chk_out("starve0", 1'b1, 4'd1, 32'h1000, 3'd1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 4'd1, 32'h1000 + 32'(k), 1'b0, 4'd0, 32'd0);
      tick();
      chk_out($sformatf("starve%0d", k), 1'b1, 4'd1, 32'h1000 + 32'(k), 3'd1, k == 8);
    end
    drive(1'b1, 4'd1, 32'h1009, 1'b0, 4'd0, 32'd0);
    tick();
    chk_out("starve_pop", 1'b1, 4'hA, 32'hAAAA, 3'd0, 1'b0);
    chk("starve.starve_cnt", 32'(bus.starve_cnt), 32'(EXP_STATS));
    drive(1'b1, 4'd1, 32'h1009, 1'b0, 4'd0, 32'd0);
    tick();
    chk_out("starve_resume", 1'b1, 4'd1, 32'h1009, 3'd0, 1'b0);

    // FIFO full: ALU held busy, five samples offered, the fifth must be refused.
    for (int j = 0; j <= 8; j++) begin
      drive(1'b1, 4'd2, 32'h2000 + 32'(j), 1'b1, 4'(4 + (j < 4 ? j : 4)),
            32'h3000 + 32'(j < 4 ? j : 4));
      if (j >= 4) begin
        chk($sformatf("full%0d.smp_ready", j), 32'(bus.smp_ready), 32'd0);
      end
      tick();
      chk_out($sformatf("full%0d", j), 1'b1, 4'd2, 32'h2000 + 32'(j),
              3'(j < 3 ? j + 1 : 4), j == 8);
    end
    drive(1'b1, 4'd2, 32'h2008, 1'b1, 4'd8, 32'h3004);
    tick();
    chk_out("full_pop", 1'b1, 4'd4, 32'h3000, 3'd3, 1'b0);

    // Asynchronous reset with three samples queued.
    #1;
    reset         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.smp_valid = 1'b0;
    #1;
    chk("areset.fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("areset.regwrite", 32'(bus.regwrite), 32'd0);
    chk("areset.starve_cnt", 32'(bus.starve_cnt), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("post_reset%0d.regwrite", n), 32'(bus.regwrite), 32'd0);
      chk($sformatf("post_reset%0d.fifo_count", n), 32'(bus.fifo_count), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Merges two write sources into the single register-file write port (regwrite/dst_addr/data_in): ALU results and incoming audio samples from the codec deserializer.
- ALU writes have priority and see no backpressure. Samples are buffered in a small FIFO and drained into free write slots.
- A starvation counter forces a one-cycle ALU stall so that queued samples always make progress.

Parameters:
- WIDTH, 32: data width; matches the register file.
- REGBITS, 4: register address width.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two, ≥2.
- STARVE_MAX, 8: consecutive cycles a non-empty FIFO may be blocked before a stall is forced; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write request this cycle.
- alu_dst  in  REGBITS  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- alu_stall  out  1  registered; when 1 the ALU must hold its request, and alu_valid is ignored this cycle.
- smp_valid  in  1  sample offered.
- smp_ready  out  1  FIFO can accept; a transfer occurs when smp_valid && smp_ready.
- smp_dst  in  REGBITS  destination register for the sample.
- smp_data  in  WIDTH  sample value.
- regwrite  out  1  to register file, registered.
- dst_addr  out  REGBITS  to register file, registered.
- data_in  out  WIDTH  to register file, registered.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- starve_cnt  out  16  forced-stall event count; see Optional Feature.

Behaviour:
- Reset (async, reset=0):
  - regwrite=0, dst_addr=0, data_in=0, alu_stall=0.
  - FIFO emptied: fifo_count=0, smp_ready=1 once reset is released.
  - Starvation counter=0, starve_cnt=0.
  - A reset asserted mid-operation discards queued samples; no partial write is issued.
- Slot selection each cycle N, evaluated from registered state:
  - GRANT_ALU: alu_valid=1 and alu_stall=0. Cycle N+1: regwrite=1, dst_addr=alu_dst, data_in=alu_data.
  - GRANT_FIFO: not GRANT_ALU and FIFO non-empty. Head is popped; cycle N+1: regwrite=1 with the head entry.
  - IDLE: otherwise; cycle N+1: regwrite=0, and dst_addr/data_in hold their previous values.
- Latency: exactly 1 cycle from accepted request to regwrite, for both sources.
- FIFO:
  - smp_ready = (fifo_count != FIFO_DEPTH). The full check is conservative: a push is refused when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ordering is FIFO order; a push into an empty FIFO cannot be popped in the same cycle (1-cycle minimum residency).
- Starvation counter (8-bit):
  - Increments on each cycle that is GRANT_ALU while the FIFO is non-empty.
  - Clears on GRANT_FIFO, or when the FIFO is empty.
  - When it reaches STARVE_MAX, alu_stall=1 for exactly the next cycle and the counter clears. During that cycle the FIFO head is written.
  - alu_stall never asserts for two consecutive cycles.
- Same-register conflict: writes are applied in grant order. No coalescing; the later write wins in the register file.
- alu_stall=1 while alu_valid=0 is legal and has no side effect beyond the FIFO grant.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined: starve_cnt increments by 1 on each forced stall and saturates at 16'hFFFF. It is cleared by reset only.
- Undefined: starve_cnt is tied to 0 and no counter logic is built. The port list is unchanged.

Decomposition:
- Shared package wb_pkg holds:
  - localparam FIFO_AW = $clog2(FIFO_DEPTH);
  - the grant enum {IDLE, GRANT_ALU, GRANT_FIFO};
  - the entry struct {dst[REGBITS], data[WIDTH]}.
- One sub-module, wb_sample_fifo: synchronous-write, registered-pointer FIFO exposing push/pop/head/count/full/empty.
- Arbitration, starvation counter and output registers stay in wb_arbiter.

Test Plan:
- Reset release: all outputs at reset values; smp_ready=1; fifo_count=0.
- Single ALU write: alu_valid=1, alu_dst=3, alu_data=32'hDEADBEEF at cycle 5 → regwrite=1, dst_addr=3, data_in=32'hDEADBEEF at cycle 6 only.
- Sample drain with idle ALU:
  - Push samples (dst 7, 0x100) then (dst 8, 0x200) on consecutive cycles.
  - Expect writes to 7 then 8 on consecutive cycles, starting 2 cycles after the first push.
  - fifo_count returns to 0.
- Full FIFO:
  - alu_valid held at 1 with STARVE_MAX=8; push 5 samples.
  - smp_ready drops after the 4th push; the 5th sample is held by the source.
  - fifo_count=4 and the 5th transfer is refused.
- Starvation:
  - Continuous alu_valid with one queued sample.
  - After 8 ALU grants, alu_stall=1 for one cycle and the sample's write appears in the next cycle.
  - With WB_ARB_STATS_EN, starve_cnt=1.
- Async reset mid-operation: assert reset with fifo_count=3 → fifo_count=0 and regwrite=0 immediately; after release, no stale sample writes occur.
